// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: h/v counters, line/frame markers, frame counter,
// and sync/data-enable outputs delayed to match the downstream pixel pipeline.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int HSYNC_POL  = 0,
  parameter int VSYNC_POL  = 0,
  parameter int PIPE_DELAY = 2,
  parameter int CNT_W      = 10,
  parameter int FRAME_W    = 8
) (
  input  logic               pixel_clk,
  input  logic               reset,
  input  logic               run,
  output logic [CNT_W-1:0]   horiz_count,
  output logic [CNT_W-1:0]   vert_count,
  output logic               active,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count,
  output logic               hsync,
  output logic               vsync,
  output logic               de
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic HS_ON = 1'(HSYNC_POL);
  localparam logic VS_ON = 1'(VSYNC_POL);

  if (PIPE_DELAY < 1 || PIPE_DELAY > 4) begin : g_bad_pipe_delay
    $error("vga_timing_gen: PIPE_DELAY must be in 1..4");
  end
  if ((2 ** CNT_W) < H_TOTAL || (2 ** CNT_W) < V_TOTAL) begin : g_bad_cnt_w
    $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
  end

  logic h_wrap;
  logic v_wrap;
  logic hs_raw;
  logic vs_raw;

  // Pipelines carry the raw (asserted = 1) decode; polarity is applied at the output.
  logic [PIPE_DELAY-1:0] hs_pipe;
  logic [PIPE_DELAY-1:0] vs_pipe;
  logic [PIPE_DELAY-1:0] de_pipe;

  assign h_wrap = (horiz_count == H_LAST);
  assign v_wrap = (vert_count == V_LAST);

  assign active = (horiz_count < H_VIS) && (vert_count < V_VIS);
  assign hs_raw = (horiz_count >= HS_FIRST) && (horiz_count <= HS_LAST);
  assign vs_raw = (vert_count >= VS_FIRST) && (vert_count <= VS_LAST);

  assign line_start  = run && (horiz_count == '0);
  assign frame_start = run && (horiz_count == '0) && (vert_count == '0);

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      horiz_count <= '0;
      vert_count  <= '0;
      frame_count <= '0;
      hs_pipe     <= '0;
      vs_pipe     <= '0;
      de_pipe     <= '0;
    end else if (run) begin
      if (h_wrap) begin
        horiz_count <= '0;
        if (v_wrap) begin
          vert_count  <= '0;
          frame_count <= frame_count + 1'b1;
        end else begin
          vert_count <= vert_count + 1'b1;
        end
      end else begin
        horiz_count <= horiz_count + 1'b1;
      end

      hs_pipe[0] <= hs_raw;
      vs_pipe[0] <= vs_raw;
      de_pipe[0] <= active;
      for (int i = 1; i < PIPE_DELAY; i++) begin
        hs_pipe[i] <= hs_pipe[i-1];
        vs_pipe[i] <= vs_pipe[i-1];
        de_pipe[i] <= de_pipe[i-1];
      end
    end
  end

  assign hsync = hs_pipe[PIPE_DELAY-1] ? HS_ON : ~HS_ON;
  assign vsync = vs_pipe[PIPE_DELAY-1] ? VS_ON : ~VS_ON;
  assign de    = de_pipe[PIPE_DELAY-1];

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator, clocked from an externally supplied pixel_clk (no internal PLL). Produces horizontal/vertical counters, line/frame markers, a frame counter, and sync/data-enable outputs delayed by a configurable number of pixel clocks to align with downstream pixel-generation pipeline latency. Sits between the clock source and the pixel generator; it is the timing source for every display mode.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync pulse width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync pulse width (lines)
V_BP, 33, vertical back porch (lines)
HSYNC_POL, 0, asserted hsync level (0 = active-low)
VSYNC_POL, 0, asserted vsync level (0 = active-low)
PIPE_DELAY, 2, clocks of delay on hsync/vsync/de; legal range 1..4
CNT_W, 10, counter width; must hold H_TOTAL-1 and V_TOTAL-1
FRAME_W, 8, frame counter width

Ports:
pixel_clk  input  1  pixel clock
reset  input  1  asynchronous, active-high reset
run  input  1  advance enable; low stalls the entire block
horiz_count  output  CNT_W  current column, 0..H_TOTAL-1
vert_count  output  CNT_W  current line, 0..V_TOTAL-1
active  output  1  undelayed visible-region flag for current counts
line_start  output  1  one-clock marker, horiz_count==0
frame_start  output  1  one-clock marker, counts == (0,0)
frame_count  output  FRAME_W  completed-frame counter
hsync  output  1  delayed horizontal sync
vsync  output  1  delayed vertical sync
de  output  1  delayed data enable (active delayed by PIPE_DELAY)

Behaviour:
- Reset value is "Already decided": reset reset, asynchronous, active-high; clock pixel_clk.
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- Reset values: horiz_count=0, vert_count=0, frame_count=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL, de=0. All PIPE_DELAY pipeline stages are cleared to the deasserted levels.
- Counting (run=1): horiz_count increments each clock. At H_TOTAL-1 it wraps to 0 and vert_count increments. vert_count at V_TOTAL-1 together with a horizontal wrap wraps to 0 and increments frame_count, which wraps modulo 2^FRAME_W.
- active = (horiz_count < H_ACTIVE) && (vert_count < V_ACTIVE). It is combinational from the registered counts.
- Raw sync decode:
  - hsync asserted for horiz_count in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (default 656..751).
  - vsync asserted for vert_count in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (default 490..491), across full lines.
  - Both ranges are inclusive. Every line is exactly H_TOTAL clocks; every frame is exactly H_TOTAL*V_TOTAL clocks.
- Pipeline: raw hsync/vsync/active enter a PIPE_DELAY-deep register chain. The hsync/vsync/de outputs equal the raw values of the counts present PIPE_DELAY run-cycles earlier, with polarity applied.
- line_start = run && horiz_count==0. frame_start = run && horiz_count==0 && vert_count==0. Both are undelayed and aligned with the counts.
- After reset release with run=1, frame_start and line_start are high in the first clock.
- Stall (run=0):
  - counters, frame_count and the pipeline hold their values; outputs are frozen.
  - line_start and frame_start are forced to 0.
  - On run returning to 1, counting resumes from the held values with no skipped or repeated count.
- Reset mid-frame: all state returns to reset values asynchronously. The next frame starts at (0,0) after release.
- Elaboration must fail if PIPE_DELAY is outside 1..4, or if 2^CNT_W < max(H_TOTAL, V_TOTAL).

Test Plan:
- Reset: assert reset mid-line at default parameters -> counts 0, frame_count 0, hsync=1, vsync=1, de=0 immediately. After release with run=1 -> frame_start=1 on first clock, horiz_count=1 on second.
- Default horizontal timing, PIPE_DELAY=2 -> hsync low in exactly the 96 clocks seen while horiz_count reads 658..753. de high for 640 clocks/line on lines 0..479. Line period 800 clocks.
- Small config (H 8/2/3/1, V 4/1/1/1, PIPE_DELAY=1, HSYNC_POL=1, VSYNC_POL=1) -> H_TOTAL=14, V_TOTAL=7. hsync high at delayed h=10..12; vsync high during line 5. frame_start every 98 clocks; frame_count reaches 3 after 294 clocks.
- frame_count wrap with FRAME_W=2 on small config -> reads 0,1,2,3,0 at successive frame_start.
- Stall: drop run for 5 clocks at horiz_count=7 -> counts, de, hsync and vsync frozen; no line_start/frame_start pulses. Resume yields 8 on the next clock, and total frame length grows by exactly 5 clocks.
- Reset mid-frame at vert_count=3 on small config -> immediate reset values. The post-release frame is a full 98 clocks.
